// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game core.
package whack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_UP,
    ST_GAP,
    ST_DONE
  } state_t;

  // Mole up-time in ms ticks, indexed by latched difficulty.
  localparam int unsigned UP_MS [4] = '{1000, 750, 500, 250};
  localparam int unsigned GAP_MS     = 200;
  localparam int unsigned MS_PER_SEC = 1000;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

endpackage

// File: rtl/whack_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used to pick mole holes.
module whack_lfsr
  import whack_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= LFSR_SEED;
    end else begin
      value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
    end
  end

endmodule

// File: rtl/whack_game_core.sv
// Whack-a-mole round controller: ms prescaler, round timer, mole FSM and scoring.
// Handshake-free: start is a 1-cycle pulse, pause/tap are levels sampled every clk.
module whack_game_core
  import whack_pkg::*;
#(
  parameter int N_HOLES   = 8,
  parameter int TICK_DIV  = 100000,
  parameter int ROUND_SEC = 30,
  parameter int SCORE_W   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pause,
  input  logic [1:0]         difficulty,
  input  logic [N_HOLES-1:0] tap,
  output logic [N_HOLES-1:0] holes,
  output logic [SCORE_W-1:0] score,
  output logic [5:0]         time_left,
  output logic               running,
  output logic               game_over,
  output state_t             dbg_state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [15:0]        lfsr_value;
  logic               lfsr_unused;
  state_t             state;
  logic [PW-1:0]      presc;
  logic [9:0]         ms_cnt;
  logic [9:0]         phase_cnt;
  logic [1:0]         diff_q;
  logic [3:0]         prev_idx;
  logic [N_HOLES-1:0] tap_q;

  logic               active;
  logic               ms_tick;
  logic               sec_wrap;
  logic               expire;
  logic               live;
  logic               hit;
  logic               wrong;
  logic [N_HOLES-1:0] tap_rise;
  logic [3:0]         raw_idx;
  logic [3:0]         spawn_idx;

  whack_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .value (lfsr_value)
  );

  assign lfsr_unused = ^lfsr_value[15:4];
  assign dbg_state   = state;

  always_comb begin
    active    = (state == ST_SPAWN) || (state == ST_UP) || (state == ST_GAP);
    ms_tick   = active && !pause && (presc == PW'(TICK_DIV - 1));
    sec_wrap  = ms_tick && (ms_cnt == 10'(MS_PER_SEC - 1));
    expire    = sec_wrap && (time_left == 6'd1);
    tap_rise  = tap & ~tap_q;
    live      = (state == ST_UP) && !pause;
    hit       = live && |(tap_rise & holes);
    wrong     = live && |(tap_rise & ~holes);
    raw_idx   = 4'(32'(lfsr_value[3:0]) % N_HOLES);
    // Never light the same hole twice in a row.
    spawn_idx = (raw_idx == prev_idx) ? 4'((32'(raw_idx) + 1) % N_HOLES) : raw_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      holes     <= '0;
      score     <= '0;
      time_left <= 6'(ROUND_SEC);
      running   <= 1'b0;
      game_over <= 1'b0;
      presc     <= '0;
      ms_cnt    <= '0;
      phase_cnt <= '0;
      diff_q    <= '0;
      prev_idx  <= '0;
      tap_q     <= '0;
    end else begin
      tap_q     <= tap;
      game_over <= 1'b0;
      if (active && !pause) begin
        presc <= (presc == PW'(TICK_DIV - 1)) ? '0 : presc + PW'(1);
      end
      if (start) begin
        state     <= ST_SPAWN;
        diff_q    <= difficulty;
        score     <= '0;
        time_left <= 6'(ROUND_SEC);
        presc     <= '0;
        ms_cnt    <= '0;
        phase_cnt <= '0;
        holes     <= '0;
        running   <= 1'b1;
      end else begin
        // A hit wins over a simultaneous wrong tap.
        if (hit) begin
          if (score != '1) score <= score + SCORE_W'(1);
        end else if (wrong && diff_q >= 2'd2 && score != '0) begin
          score <= score - SCORE_W'(1);
        end
        if (ms_tick) ms_cnt <= sec_wrap ? '0 : ms_cnt + 10'd1;
        if (sec_wrap) time_left <= time_left - 6'd1;

        if (expire) begin
          state     <= ST_DONE;
          holes     <= '0;
          running   <= 1'b0;
          game_over <= 1'b1;
        end else begin
          case (state)
            ST_SPAWN: begin
              holes     <= N_HOLES'(1) << spawn_idx;
              prev_idx  <= spawn_idx;
              phase_cnt <= '0;
              state     <= ST_UP;
            end
            ST_UP: begin
              if (hit || (ms_tick && phase_cnt == 10'(UP_MS[diff_q] - 1))) begin
                holes     <= '0;
                phase_cnt <= '0;
                state     <= ST_GAP;
              end else if (ms_tick) begin
                phase_cnt <= phase_cnt + 10'd1;
              end
            end
            ST_GAP: begin
              if (ms_tick) begin
                if (phase_cnt == 10'(GAP_MS - 1)) begin
                  phase_cnt <= '0;
                  state     <= ST_SPAWN;
                end else begin
                  phase_cnt <= phase_cnt + 10'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
